// File: rtl/tw_sched64.sv
// tw_sched64: twiddle-index scheduler for a 64-sample frame.
// Walks the sample counter n over accepted samples, drives the twiddle unit
// with a registered enable/index/direction, and tracks the twiddle-unit
// latency so o_done lands the cycle after the last o_out_valid of a frame.
// Optional feature: define TW_SCHED64_BYPASS_FLAG_EN to add o_tw_byp, which
// flags samples whose twiddle factor is trivially 1+0j.
// Handshake: a sample transfers on a rising clk edge where i_valid && o_ready;
// o_ready is high only in RUN, and i_valid carries no hold obligation.
module tw_sched64 #(
   parameter int NS       = 64,  // frame length; only 64 is supported
   parameter int MULT_LAT = 1    // twiddle-unit latency, 1..4
) (
   input  logic       clk,
   input  logic       rst_async_n,
   input  logic       i_start,
   input  logic       i_inv,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_tw_en,
   output logic [5:0] o_tw_idx,
   output logic       o_tw_inv,
   output logic       o_sof,
   output logic       o_eof,
   output logic       o_out_valid,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_err,
`ifdef TW_SCHED64_BYPASS_FLAG_EN
   output logic       o_tw_byp,
`endif
   output logic [1:0] o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   localparam logic [5:0] LAST_IDX   = 6'(NS - 1);
   localparam logic [2:0] FLUSH_LAST = 3'(MULT_LAT);

   state_t              state_q;
   state_t              state_d;
   logic [5:0]          n_q;
   logic [2:0]          flush_cnt_q;
   logic [MULT_LAT-1:0] vld_sr_q;
   logic                accept;
   logic                last_accept;
   logic                flush_end;

   assign accept      = i_valid && (state_q == S_RUN);
   assign last_accept = accept && (n_q == LAST_IDX);
   // FLUSH spans the registered enable cycle plus MULT_LAT multiplier cycles.
   assign flush_end   = (state_q == S_FLUSH) && (flush_cnt_q == FLUSH_LAST);

   assign o_ready     = (state_q == S_RUN);
   assign o_busy      = (state_q != S_IDLE);
   assign o_out_valid = vld_sr_q[MULT_LAT-1];
   assign o_dbg_state = state_q;

   // State register.
   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) state_q <= S_IDLE;
      else              state_q <= state_d;
   end

   // Next-state logic; i_start outside IDLE never affects sequencing.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (i_start)     state_d = S_RUN;
         S_RUN:   if (last_accept) state_d = S_FLUSH;
         S_FLUSH: if (flush_end)   state_d = S_IDLE;
         default:                  state_d = S_IDLE;
      endcase
   end

   // Sample counter, registered twiddle-unit controls and frame direction.
   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         n_q      <= '0;
         o_tw_en  <= 1'b0;
         o_tw_idx <= '0;
         o_tw_inv <= 1'b0;
         o_sof    <= 1'b0;
         o_eof    <= 1'b0;
      end else begin
         o_tw_en <= accept;
         o_sof   <= 1'b0;
         o_eof   <= 1'b0;
         if ((state_q == S_IDLE) && i_start) begin
            n_q      <= '0;
            o_tw_inv <= i_inv;
         end
         if (accept) begin
            o_tw_idx <= n_q;
            o_sof    <= (n_q == 6'd0);
            o_eof    <= (n_q == LAST_IDX);
            n_q      <= n_q + 6'd1;  // wraps to 0 after the last sample
         end
      end
   end

   // Flush timer, completion pulse and sticky protocol-error flag.
   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         flush_cnt_q <= '0;
         o_done      <= 1'b0;
         o_err       <= 1'b0;
      end else begin
         o_done <= flush_end;
         if (state_q == S_FLUSH) flush_cnt_q <= flush_cnt_q + 3'd1;
         else                    flush_cnt_q <= '0;
         if ((i_start && (state_q != S_IDLE)) || (i_valid && (state_q != S_RUN)))
            o_err <= 1'b1;
      end
   end

   // Delay line modelling the twiddle-unit latency on the enable.
   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         vld_sr_q <= '0;
      end else begin
         vld_sr_q[0] <= o_tw_en;
         for (int i = 1; i < MULT_LAT; i++) vld_sr_q[i] <= vld_sr_q[i-1];
      end
   end

`ifdef TW_SCHED64_BYPASS_FLAG_EN
   // Trivial twiddle (1+0j) flag, aligned with o_tw_en.
   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) o_tw_byp <= 1'b0;
      else              o_tw_byp <= accept && ((n_q[5:2] == 4'd0) || (n_q[1:0] == 2'd0));
   end
`endif

endmodule

// File: tb/tb_tw_sched64.sv
// Bench for tw_sched64: directed frames with a scoreboard of expected
// twiddle-unit transactions checked by a negedge monitor.
`timescale 1ns/1ps
module tb_tw_sched64;

   localparam int ML = 1;
   localparam int EW = 10;  // {byp, inv, eof, sof, idx[5:0]}

   logic       clk;
   logic       rst_async_n;
   logic       i_start;
   logic       i_inv;
   logic       i_valid;
   logic       o_ready;
   logic       o_tw_en;
   logic [5:0] o_tw_idx;
   logic       o_tw_inv;
   logic       o_sof;
   logic       o_eof;
   logic       o_out_valid;
   logic       o_busy;
   logic       o_done;
   logic       o_err;
   logic [1:0] o_dbg_state;
`ifdef TW_SCHED64_BYPASS_FLAG_EN
   logic       o_tw_byp;
`endif

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] exp_e;
   logic [5:0]    last_idx = 6'd0;
   int chk_cnt  = 0;
   int err_cnt  = 0;
   int cyc      = 0;
   int ov_cnt   = 0;
   int eof_cyc  = 0;
   int done_cyc = 0;
   int done_cnt = 0;

   tw_sched64 #(.NS(64), .MULT_LAT(ML)) dut (
      .clk         (clk),
      .rst_async_n (rst_async_n),
      .i_start     (i_start),
      .i_inv       (i_inv),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .o_tw_en     (o_tw_en),
      .o_tw_idx    (o_tw_idx),
      .o_tw_inv    (o_tw_inv),
      .o_sof       (o_sof),
      .o_eof       (o_eof),
      .o_out_valid (o_out_valid),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err),
`ifdef TW_SCHED64_BYPASS_FLAG_EN
      .o_tw_byp    (o_tw_byp),
`endif
      .o_dbg_state (o_dbg_state)
   );

   // Clock and cycle counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expected transaction per o_tw_en.
   always @(negedge clk) begin
      if (rst_async_n) begin
         if (o_tw_en) begin
            if (exp_q.size() == 0) begin
               check("tw_en_unexpected", 32'(o_tw_en), 32'd0);
            end else begin
               exp_e = exp_q.pop_front();
               check("tw_idx", 32'(o_tw_idx), 32'(exp_e[5:0]));
               check("sof",    32'(o_sof),    32'(exp_e[6]));
               check("eof",    32'(o_eof),    32'(exp_e[7]));
               check("tw_inv", 32'(o_tw_inv), 32'(exp_e[8]));
`ifdef TW_SCHED64_BYPASS_FLAG_EN
               check("tw_byp", 32'(o_tw_byp), 32'(exp_e[9]));
`endif
               last_idx = exp_e[5:0];
            end
         end else begin
            check("idx_hold",    32'(o_tw_idx), 32'(last_idx));
            check("sof_eof_off", 32'({o_sof, o_eof}), 32'd0);
         end
         if (o_out_valid) ov_cnt++;
         if (o_eof) eof_cyc = cyc;
         if (o_done) begin
            done_cyc = cyc;
            done_cnt++;
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"},     32'(o_ready),     32'd0);
      check({tag, "_tw_en"},     32'(o_tw_en),     32'd0);
      check({tag, "_tw_idx"},    32'(o_tw_idx),    32'd0);
      check({tag, "_tw_inv"},    32'(o_tw_inv),    32'd0);
      check({tag, "_sof"},       32'(o_sof),       32'd0);
      check({tag, "_eof"},       32'(o_eof),       32'd0);
      check({tag, "_out_valid"}, 32'(o_out_valid), 32'd0);
      check({tag, "_busy"},      32'(o_busy),      32'd0);
      check({tag, "_done"},      32'(o_done),      32'd0);
      check({tag, "_err"},       32'(o_err),       32'd0);
      check({tag, "_state"},     32'(o_dbg_state), 32'd0);
`ifdef TW_SCHED64_BYPASS_FLAG_EN
      check({tag, "_tw_byp"},    32'(o_tw_byp),    32'd0);
`endif
   endtask

   task automatic start_frame(input logic inv);
      ov_cnt = 0;
      @(posedge clk); #1;
      i_start = 1'b1;
      i_inv   = inv;
      @(posedge clk); #1;
      i_start = 1'b0;
      i_inv   = ~inv;  // direction must stay latched
   endtask

   // Drive samples first..first+cnt-1; i_start pulses alongside sample err_at.
   task automatic feed(input int first, input int cnt, input logic inv, input bit gaps, input int err_at);
      logic byp;
      for (int s = first; s < first + cnt; s++) begin
         if (gaps) begin
            i_valid = 1'b0;
            @(posedge clk); #1;
         end
         i_valid = 1'b1;
         i_start = (s == err_at);
         i_inv   = s[0];
         byp     = (s < 4) || (s % 4 == 0);
         exp_q.push_back({byp, inv, 1'(s == 63), 1'(s == 0), 6'(s)});
         @(posedge clk); #1;
         i_start = 1'b0;
         if (s == err_at) check("err_on_start_in_run", 32'(o_err), 32'd1);
      end
      i_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int start_cnt;
      bit got;
      start_cnt = done_cnt;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(posedge clk); #6;
         if (done_cnt != start_cnt) got = 1'b1;
      end
      check({tag, "_done_seen"}, 32'(got), 32'd1);
      if (got) begin
         check({tag, "_done_lat"},  32'(done_cyc - eof_cyc), 32'(ML + 1));
         check({tag, "_out_valid_cnt"}, 32'(ov_cnt), 32'd64);
         check({tag, "_busy_at_done"}, 32'(o_busy), 32'd0);
         check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
         @(posedge clk); #1;
         check({tag, "_done_pulse"}, 32'(o_done), 32'd0);
      end
   endtask

   task automatic run_frame(input string tag, input logic inv, input bit gaps, input int err_at);
      start_frame(inv);
      feed(0, 64, inv, gaps, err_at);
      wait_done(tag);
   endtask

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt + 1);
      $fatal(1);
   end

   // Directed sequence.
   initial begin
      rst_async_n = 1'b0;
      i_start     = 1'b0;
      i_inv       = 1'b0;
      i_valid     = 1'b0;
      #12;
      check_all_zero("por");
      @(posedge clk); #1;
      rst_async_n = 1'b1;

      // Back-to-back inverse frame.
      run_frame("f1", 1'b1, 1'b0, -1);
      check("f1_err", 32'(o_err), 32'd0);

      // Forward frame, valid on alternate cycles.
      run_frame("f2", 1'b0, 1'b1, -1);
      check("f2_err", 32'(o_err), 32'd0);

      // i_start during sample 30: error, frame still completes.
      run_frame("f3", 1'b1, 1'b0, 30);
      check("f3_err_sticky", 32'(o_err), 32'd1);

      // Reset between clock edges after 40 samples.
      start_frame(1'b1);
      feed(0, 40, 1'b1, 1'b0, -1);
      @(posedge clk); #2;
      rst_async_n = 1'b0;
      #1;
      check_all_zero("mid_rst");
      last_idx = 6'd0;
      #1;
      rst_async_n = 1'b1;

      // i_valid in IDLE for 5 cycles: nothing enabled, error raised.
      @(posedge clk); #1;
      i_valid = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      i_valid = 1'b0;
      check("idle_valid_err", 32'(o_err), 32'd1);
      check("idle_valid_idx", 32'(o_tw_idx), 32'd0);
      check("idle_valid_busy", 32'(o_busy), 32'd0);

      // Fresh frame from index 0; i_start coincides with the last sample.
      run_frame("f4", 1'b0, 1'b0, 63);
      repeat (3) @(posedge clk);
      #1;
      check("f4_no_restart_busy", 32'(o_busy), 32'd0);
      check("f4_no_restart_state", 32'(o_dbg_state), 32'd0);
      check("f4_err_sticky", 32'(o_err), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/tw_sched64.md
TW_SCHED64 -- requirements
Module: tw_sched64

Interface
REQ-001 SHALL have parameter NS, default 64, frame length in samples; supported value is 64 only.
REQ-002 SHALL have parameter MULT_LAT, default 1, cycles from twiddle-unit enable to its registered output; legal range 1..4.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_async_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_start, input, 1, frame start request, sampled in IDLE only.
REQ-006 SHALL have port i_inv, input, 1, direction select (0 forward, 1 inverse), latched on an accepted i_start.
REQ-007 SHALL have port i_valid, input, 1, upstream sample valid.
REQ-008 SHALL have port o_ready, output, 1, sample accept; a sample is accepted when i_valid && o_ready.
REQ-009 SHALL have port o_tw_en, output, 1, enable (i_valid) to the twiddle unit.
REQ-010 SHALL have port o_tw_idx, output, 6, twiddle table index for the enabled sample.
REQ-011 SHALL have port o_tw_inv, output, 1, latched direction for the current frame.
REQ-012 SHALL have port o_sof, output, 1, high with o_tw_en for sample 0 of a frame.
REQ-013 SHALL have port o_eof, output, 1, high with o_tw_en for sample 63 of a frame.
REQ-014 SHALL have port o_out_valid, output, 1, twiddle-unit output valid, equal to o_tw_en delayed MULT_LAT cycles.
REQ-015 SHALL have port o_busy, output, 1, high in RUN or FLUSH.
REQ-016 SHALL have port o_done, output, 1, one-cycle pulse at frame completion.
REQ-017 SHALL have port o_err, output, 1, sticky error flag.

Function
REQ-018 SHALL implement FSM states IDLE, RUN and FLUSH.
REQ-019 IDLE->RUN on i_start=1: clears sample counter n to 0 and latches i_inv into o_tw_inv.
REQ-020 o_ready SHALL be 1 in RUN only.
REQ-021 Each accepted sample SHALL register, next cycle: o_tw_en=1, o_tw_idx=n, o_sof=(n==0), o_eof=(n==63); then n increments by 1.
REQ-022 When no sample is accepted, o_tw_en, o_sof and o_eof SHALL be 0 next cycle, and o_tw_idx SHALL hold its value.
REQ-023 Acceptance of sample 63 SHALL move the FSM RUN->FLUSH; n SHALL wrap to 0.
REQ-024 FLUSH SHALL last MULT_LAT+1 cycles, covering the registered enable plus the multiplier latency; then FLUSH->IDLE, with o_done=1 for exactly the cycle in which the FSM re-enters IDLE.
REQ-025 o_done SHALL coincide with the cycle after the last o_out_valid of the frame.
REQ-026 i_start=1 while in RUN or FLUSH SHALL be ignored for sequencing and SHALL set o_err.
REQ-027 i_valid=1 in IDLE or FLUSH SHALL not be accepted, SHALL not change n, and SHALL set o_err.
REQ-028 o_err SHALL be cleared only by reset.
REQ-029 i_start and the last sample arriving in the same cycle: the sample is accepted, i_start sets o_err, and no new frame starts.
REQ-030 i_inv changes during RUN SHALL not affect o_tw_inv until the next accepted i_start.

Reset
REQ-031 Assertion of rst_async_n=0 SHALL immediately force the FSM to IDLE and n=0, at any time including mid-frame.
REQ-032 Reset values SHALL be: o_ready=0, o_tw_en=0, o_tw_idx=0, o_tw_inv=0, o_sof=0, o_eof=0, o_out_valid=0 (including the whole delay line), o_busy=0, o_done=0, o_err=0.
REQ-033 Deassertion SHALL take effect at the first rising clk edge after rst_async_n=1; no frame resumes after reset.

Configuration
REQ-034 Macro TW_SCHED64_BYPASS_FLAG_EN SHALL control an optional trivial-twiddle output.
REQ-035 With the macro defined, the block SHALL add output port o_tw_byp (1 bit), registered with o_tw_en, equal to 1 when n<4 or n[1:0]==0 (twiddle value 1+0j), else 0; reset value 0.
REQ-036 Without the macro, o_tw_byp and its logic SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-037 Reset, i_start=1 with i_inv=1, then 64 back-to-back i_valid -> o_tw_idx 0..63 on consecutive cycles, o_sof at idx 0, o_eof at idx 63, o_tw_inv=1, o_done exactly MULT_LAT+1 cycles after the o_eof cycle, o_err=0.
REQ-038 Frame with i_valid deasserted on every other cycle -> o_tw_idx still 0..63 with no gaps in index, o_tw_en only on accepted samples, o_out_valid count = 64.
REQ-039 i_start pulsed at sample 30 of a frame -> o_err=1 and stays 1, frame completes normally with 64 indices.
REQ-040 rst_async_n pulsed low between clock edges at sample 40 -> all outputs 0 immediately; a following i_start restarts at o_tw_idx=0.
REQ-041 With TW_SCHED64_BYPASS_FLAG_EN defined, one full frame -> o_tw_byp=1 at idx 0,1,2,3,4,8,12,...,60 and 0 elsewhere (19 ones).
REQ-042 i_valid=1 in IDLE for 5 cycles -> no o_tw_en, n stays 0, o_err=1.
